// File: rtl/sll_iter_pkg.sv
// Shared definitions for the iterative logical left shifter.
//   state_t       : FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width
//   shamt_width() : number of shift-amount bits (and stages) for a width
package sll_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One reusable shift stage: a WIDTH-wide row of 2:1 muxes.
//   data   : value entering this stage
//   stage  : stage index k; the shifted path moves data left by 2^k
//   en     : 1 selects the shifted path, 0 passes data through
//   result : selected value; low 2^k bits of the shifted path are zero
module sll_stage
  import sll_iter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = shamt_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] stage,
  input  logic               en,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] dist_s;
  logic [WIDTH-1:0] shifted_s;

  // Shift distance 2^stage and the zero-filled shifted candidate.
  always_comb begin
    dist_s    = {{(WIDTH-1){1'b0}}, 1'b1} << stage;
    shifted_s = data << dist_s;
  end

  // Per-bit 2:1 mux between the shifted and pass-through paths.
  always_comb begin
    result = data;
    if (en) begin
      result = shifted_s;
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: z = x << y[SHAMT_W-1:0], zero fill.
// One power-of-two stage is applied per clock through a single shared
// sll_stage, so latency is fixed at SHAMT_W shift cycles for any amount.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   x, y                : value and shift amount (upper bits of y ignored)
//   out_valid/out_ready : result handshake; z held while stalled
//   z                   : registered result
//   busy                : high while shifting or holding a result
module sll_iter
  import sll_iter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = shamt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             busy
);

  localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);
  localparam logic [SHAMT_W-1:0] STAGE_ONE  = SHAMT_W'(1);

  state_t             state_r;
  logic [WIDTH-1:0]   data_r;
  logic [SHAMT_W-1:0] amt_r;
  logic [SHAMT_W-1:0] stage_r;
  logic [SHAMT_W-1:0] stage_mask_s;
  logic               stage_en_s;
  logic [WIDTH-1:0]   stage_out_s;
  logic               unused_y_s;

  // The upper shift-amount bits are architecturally ignored.
  assign unused_y_s = ^y[WIDTH-1:SHAMT_W];

  // Select the amount bit belonging to the current stage.
  always_comb begin
    stage_mask_s = STAGE_ONE << stage_r;
    stage_en_s   = |(amt_r & stage_mask_s);
  end

  sll_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .data   (data_r),
    .stage  (stage_r),
    .en     (stage_en_s),
    .result (stage_out_s)
  );

  // Handshake FSM with the data, amount and stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      data_r    <= {WIDTH{1'b0}};
      amt_r     <= {SHAMT_W{1'b0}};
      stage_r   <= {SHAMT_W{1'b0}};
      z         <= {WIDTH{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_r   <= x;
            amt_r    <= y[SHAMT_W-1:0];
            stage_r  <= {SHAMT_W{1'b0}};
            state_r  <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          data_r <= stage_out_s;
          if (stage_r == LAST_STAGE) begin
            // Final stage: the result goes straight into z so it is
            // visible together with out_valid.
            z         <= stage_out_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            stage_r <= stage_r + STAGE_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sll_iter.sv
// Directed testbench for sll_iter (WIDTH=32). Inputs change and outputs
// are sampled on the falling edge; the design acts on the rising edge.
module tb_sll_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sll_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operand, then wait (out_ready low) for the result and check
  // the latency from the accept edge and the result value.
  task automatic start_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] exp_z);
    int lat;
    out_ready = 1'b0;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x = xv;
    y = yv;
    @(negedge clk);
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " z"}, z, exp_z);
  endtask

  // Complete the output handshake and check the return to IDLE.
  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] hold_z;
    logic [31:0] xv, yv, exp_z;
    int          n;
    bit          seen;
    bit          done;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 32'd0;
    y         = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset z", z, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Maximum shift of a single bit.
    start_op("t1", 32'h0000_0001, 32'd31, 32'h8000_0000);
    finish_op("t1");

    // Zero shift, and an amount whose upper bits must be ignored.
    start_op("t2a", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    finish_op("t2a");
    start_op("t2b", 32'hFFFF_FFFF, 32'h0000_0024, 32'hFFFF_FFF0);
    finish_op("t2b");
    start_op("t2c", 32'h0000_1357, 32'd32, 32'h0000_1357);
    finish_op("t2c");
    start_op("t2d", 32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000);
    finish_op("t2d");

    // Backpressure: result must hold and new operands must be refused.
    start_op("t3", 32'h1234_5678, 32'd8, 32'h3456_7800);
    hold_z = z;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x = $urandom;
      y = $urandom;
      @(negedge clk);
      check("t3 hold out_valid", 32'(out_valid), 32'd1);
      check("t3 hold z", z, 32'h3456_7800);
      check("t3 hold in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finish_op("t3");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("t3 single handshake", 32'(seen), 32'd0);
    check("t3 z held in idle", z, hold_z);

    // Reset in the middle of SHIFT discards the operation.
    in_valid = 1'b1;
    x = 32'hA5A5_A5A5;
    y = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t4 out_valid", 32'(out_valid), 32'd0);
    check("t4 z", z, 32'd0);
    check("t4 in_ready", 32'(in_ready), 32'd1);
    check("t4 busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("t4 no result", 32'(seen), 32'd0);

    // Throughput with out_ready tied high: accepts SHAMT_W+2 cycles apart.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x = 32'h0000_00FF;
    y = 32'd4;
    @(negedge clk);
    n = 1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tput interval", 32'(n), 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tput second z", z, 32'h0000_0FF0);
    @(negedge clk);
    out_ready = 1'b0;
    check("tput idle", 32'(in_ready), 32'd1);

    // Random stream with random output backpressure.
    for (int k = 0; k < 300; k++) begin
      xv = $urandom;
      yv = $urandom;
      exp_z = xv << yv[4:0];
      check("rand in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      x = xv;
      y = yv;
      @(negedge clk);
      in_valid = 1'b0;
      x = $urandom;
      y = $urandom;
      done = 1'b0;
      n = 0;
      while (!done && n < 60) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check("rand z", z, exp_z);
          done = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      out_ready = 1'b0;
      check("rand completed", 32'(done), 32'd1);
    end

    // Shift sweep over every amount.
    for (int s = 0; s < 32; s++) begin
      xv = 32'h8000_0001;
      exp_z = xv << s;
      start_op("sweep", xv, 32'(s), exp_z);
      finish_op("sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
